// File: rtl/alu_pkg.sv
// Shared types for the ALU result capture path.
// alu_result_t is the record stored per captured ALU result.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;

  typedef struct packed {
    logic [ALU_SEL_W-1:0] sel;
    logic                 carry;
    logic                 zero;
    logic [ALU_WIDTH-1:0] result;
  } alu_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word fall-through FIFO: head entry is read straight from storage.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  data_t                    din,
  input  logic                     pop,
  output data_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  data_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg, count_next;
  logic               do_push, do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // Storage has no reset; each entry only loads when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && wr_ptr_reg == PTR_W'(gi)) begin
        mem[gi] <= din;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results with a derived zero flag into a FIFO drained by valid/ready,
// and counts cycles where upstream was held off by a full buffer.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     carry_out,
  input  logic [SEL_W-1:0]         alu_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [SEL_W-1:0]         out_sel,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         stall_cnt
);

  alu_result_t      wr_entry, rd_entry;
  logic             full, empty;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  always_comb begin
    wr_entry        = '0;
    wr_entry.sel    = alu_sel;
    wr_entry.carry  = carry_out;
    wr_entry.zero   = (alu_out == '0);
    wr_entry.result = alu_out;
  end

  sync_fifo #(
    .data_t (alu_result_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (wr_entry),
    .pop   (out_ready),
    .dout  (rd_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign out_result = rd_entry.result;
  assign out_carry  = rd_entry.carry;
  assign out_zero   = rd_entry.zero;
  assign out_sel    = rd_entry.sel;

  // Saturating: holds at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (in_valid && full && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_reg <= '0;
    else        stall_cnt_reg <= stall_cnt_next;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench: table of single-cycle vectors plus hand sequences for
// streaming, asynchronous reset and stall-counter saturation.
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [3:0] alu_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic [3:0] out_sel;
  logic [2:0] count;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(
    .WIDTH (8),
    .SEL_W (4),
    .DEPTH (4),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .alu_sel    (alu_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_sel    (out_sel),
    .count      (count),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic       iv;
    logic [7:0] a;
    logic       c;
    logic [3:0] s;
    logic       ordy;
    logic       e_ov;
    logic       e_ir;
    logic [2:0] e_cnt;
    logic [3:0] e_stall;
    logic [7:0] e_res;
    logic       e_c;
    logic       e_z;
    logic [3:0] e_sel;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic iv, logic [7:0] a, logic c, logic [3:0] s, logic ordy,
                              logic e_ov, logic e_ir, logic [2:0] e_cnt, logic [3:0] e_stall,
                              logic [7:0] e_res, logic e_c, logic e_z, logic [3:0] e_sel);
    vec_t v;
    v.iv = iv; v.a = a; v.c = c; v.s = s; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_stall = e_stall;
    v.e_res = e_res; v.e_c = e_c; v.e_z = e_z; v.e_sel = e_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] a, input logic c,
                       input logic [3:0] s, input logic ordy);
    in_valid  = iv;
    alu_out   = a;
    carry_out = c;
    alu_sel   = s;
    out_ready = ordy;
  endtask

  task automatic check_head(input string tag, input logic [7:0] res, input logic c,
                            input logic z, input logic [3:0] s);
    check({tag, ".out_valid"},  32'(out_valid),  32'd1);
    check({tag, ".out_result"}, 32'(out_result), 32'(res));
    check({tag, ".out_carry"},  32'(out_carry),  32'(c));
    check({tag, ".out_zero"},   32'(out_zero),   32'(z));
    check({tag, ".out_sel"},    32'(out_sel),    32'(s));
  endtask

  initial begin
    // in_valid, data, carry, sel, out_ready -> out_valid, in_ready, count, stall, head
    vecs[0]  = mk(1, 8'h00, 0, 4'h7, 0,  1, 1, 3'd1, 4'd0, 8'h00, 0, 1, 4'h7);
    vecs[1]  = mk(0, 8'h00, 0, 4'h0, 1,  0, 1, 3'd0, 4'd0, 8'h00, 0, 0, 4'h0);
    vecs[2]  = mk(1, 8'h01, 0, 4'h1, 0,  1, 1, 3'd1, 4'd0, 8'h01, 0, 0, 4'h1);
    vecs[3]  = mk(1, 8'h02, 0, 4'h2, 0,  1, 1, 3'd2, 4'd0, 8'h01, 0, 0, 4'h1);
    vecs[4]  = mk(1, 8'h03, 0, 4'h3, 0,  1, 1, 3'd3, 4'd0, 8'h01, 0, 0, 4'h1);
    vecs[5]  = mk(1, 8'hFF, 1, 4'h4, 0,  1, 0, 3'd4, 4'd0, 8'h01, 0, 0, 4'h1);
    vecs[6]  = mk(1, 8'h55, 0, 4'h0, 0,  1, 0, 3'd4, 4'd1, 8'h01, 0, 0, 4'h1);
    vecs[7]  = mk(1, 8'h55, 0, 4'h0, 0,  1, 0, 3'd4, 4'd2, 8'h01, 0, 0, 4'h1);
    vecs[8]  = mk(1, 8'h55, 0, 4'h0, 0,  1, 0, 3'd4, 4'd3, 8'h01, 0, 0, 4'h1);
    // Full with pop: pop happens, push is refused, stall still counts.
    vecs[9]  = mk(1, 8'h77, 0, 4'hE, 1,  1, 1, 3'd3, 4'd4, 8'h02, 0, 0, 4'h2);
    vecs[10] = mk(0, 8'h00, 0, 4'h0, 1,  1, 1, 3'd2, 4'd4, 8'h03, 0, 0, 4'h3);
    vecs[11] = mk(0, 8'h00, 0, 4'h0, 1,  1, 1, 3'd1, 4'd4, 8'hFF, 1, 0, 4'h4);
    vecs[12] = mk(0, 8'h00, 0, 4'h0, 1,  0, 1, 3'd0, 4'd4, 8'h00, 0, 0, 4'h0);

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 4'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset then idle
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready",  32'(in_ready),  32'd1);
    check("reset.count",     32'(count),     32'd0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);

    // Single push, fill/stall, drain
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].a, vecs[i].c, vecs[i].s, vecs[i].ordy);
      tick();
      $display("vec %0d: iv=%0b a=%02h or=%0b -> ov=%0b ir=%0b cnt=%0d stall=%0d res=%02h",
               i, vecs[i].iv, vecs[i].a, vecs[i].ordy, out_valid, in_ready, count, stall_cnt, out_result);
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
      if (vecs[i].e_ov)
        check_head($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_c, vecs[i].e_z, vecs[i].e_sel);
    end

    // Streaming at count=2: 12 pushes total, pointers wrap several times
    drive(1, 8'h10, 0, 4'h0, 0); tick();
    drive(1, 8'h11, 1, 4'h1, 0); tick();
    check("stream.prefill.count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic [7:0] h;
      d = 8'h12 + 8'(i);
      h = 8'h11 + 8'(i);
      drive(1, d, d[0], d[3:0], 1);
      tick();
      $display("stream %0d: push=%02h head=%02h cnt=%0d", i, d, out_result, count);
      check($sformatf("stream%0d.count", i), 32'(count), 32'd2);
      check_head($sformatf("stream%0d", i), h, h[0], 1'b0, h[3:0]);
    end
    drive(0, 8'h00, 0, 4'h0, 1); tick();
    check("stream.drain1.count", 32'(count), 32'd1);
    check_head("stream.drain1", 8'h1B, 1'b1, 1'b0, 4'hB);
    tick();
    check("stream.drain2.out_valid", 32'(out_valid), 32'd0);
    check("stream.drain2.count",     32'(count),     32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h21 + 8'(i), 0, 4'h5, 0);
      tick();
    end
    drive(0, 8'h00, 0, 4'h0, 0);
    check("areset.pre.count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted: ov=%0b cnt=%0d", out_valid, count);
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.count",     32'(count),     32'd0);
    check("areset.in_ready",  32'(in_ready),  32'd1);
    check("areset.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h5A, 1, 4'h9, 0);
    tick();
    check("areset.post.count", 32'(count), 32'd1);
    check_head("areset.post", 8'h5A, 1'b1, 1'b0, 4'h9);

    // Stall saturation (CNT_W=4)
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h60 + 8'(i), 0, 4'h1, 0);
      tick();
    end
    check("sat.full.count",    32'(count),    32'd4);
    check("sat.full.in_ready", 32'(in_ready), 32'd0);
    drive(1, 8'hAA, 0, 4'h2, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("sat.k14.stall_cnt", 32'(stall_cnt), 32'hE);
      if (k == 15) check("sat.k15.stall_cnt", 32'(stall_cnt), 32'hF);
      if (k == 20) check("sat.k20.stall_cnt", 32'(stall_cnt), 32'hF);
    end
    $display("saturation: stall_cnt=%0h cnt=%0d", stall_cnt, count);
    check("sat.end.count", 32'(count), 32'd4);
    check_head("sat.end", 8'h5A, 1'b1, 1'b0, 4'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
